clause_formula_loader: RTL and testbench

Setup-side driver for the gain/clause-checking datapath. Holds a host-written copy of the formula (one integer part and one boolean part per clause). On command, it streams every clause in index order onto the clause-register setup bus, one clause per clock. It then raises a done flag and a checker enable so the downstream gain computation may start evaluating assignments.

---
 rtl/clause_formula_loader_if.sv | 53 +++++
 rtl/clause_formula_loader.sv | 102 ++++++++++
 tb/tb_clause_formula_loader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/clause_formula_loader_if.sv
// Host-write / setup-bus bundle for clause_formula_loader.
// CLAUSE_FORMULA_LOADER_CHECKSUM_EN adds out_checksum.
interface clause_formula_loader_if #(
  parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT    = 4,
  parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT    = 2,
  parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1,
  parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 1,
  parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX          = 2
);
  localparam int IV = 2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX;
  localparam int BV = 2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX;
  localparam int IW = (IV+1)*MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT;
  localparam int BW = BV*MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT;
  localparam int CW = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX;

  logic          in_wr_en;
  logic [CW-1:0] in_wr_index;
  logic [IW-1:0] in_wr_coefficients_integer;
  logic [BW-1:0] in_wr_coefficients_boolean;
  logic          in_start;
  logic [IW-1:0] out_clause_coefficients_integer;
  logic [BW-1:0] out_clause_coefficients_boolean;
  logic [CW-1:0] out_clause_index;
  logic          out_clause_valid;
  logic          out_busy;
  logic          out_setup_done;
  logic          out_checker_enable;
`ifdef CLAUSE_FORMULA_LOADER_CHECKSUM_EN
  logic [IW+BW-1:0] out_checksum;

  modport master (
    output in_wr_en, in_wr_index, in_wr_coefficients_integer, in_wr_coefficients_boolean, in_start,
    input  out_clause_coefficients_integer, out_clause_coefficients_boolean, out_clause_index,
           out_clause_valid, out_busy, out_setup_done, out_checker_enable, out_checksum
  );
  modport slave (
    input  in_wr_en, in_wr_index, in_wr_coefficients_integer, in_wr_coefficients_boolean, in_start,
    output out_clause_coefficients_integer, out_clause_coefficients_boolean, out_clause_index,
           out_clause_valid, out_busy, out_setup_done, out_checker_enable, out_checksum
  );
`else
  modport master (
    output in_wr_en, in_wr_index, in_wr_coefficients_integer, in_wr_coefficients_boolean, in_start,
    input  out_clause_coefficients_integer, out_clause_coefficients_boolean, out_clause_index,
           out_clause_valid, out_busy, out_setup_done, out_checker_enable
  );
  modport slave (
    input  in_wr_en, in_wr_index, in_wr_coefficients_integer, in_wr_coefficients_boolean, in_start,
    output out_clause_coefficients_integer, out_clause_coefficients_boolean, out_clause_index,
           out_clause_valid, out_busy, out_setup_done, out_checker_enable
  );
`endif
endinterface

// File: rtl/clause_formula_loader.sv
// Holds the host-written formula and streams it clause by clause onto the setup bus.
// CLAUSE_FORMULA_LOADER_CHECKSUM_EN adds an XOR checksum of the streamed clauses.
module clause_formula_loader #(
  parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT    = 4,
  parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT    = 2,
  parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1,
  parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 1,
  parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX          = 2
) (
  input logic                   in_clk,
  input logic                   in_reset,
  clause_formula_loader_if.slave bus
);
  localparam int IV = 2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX;
  localparam int BV = 2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX;
  localparam int IW = (IV+1)*MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT;
  localparam int BW = BV*MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT;
  localparam int CW = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX;
  localparam int N  = 2**CW;
  localparam int EW = IW+BW;

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          settle_last;
  logic [EW-1:0] mem [N];
  logic          wr_ok;
  logic [EW-1:0] cur;

  assign wr_ok = (state == IDLE) || (state == DONE);
  assign cur   = mem[cnt];

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state       <= IDLE;
      cnt         <= '0;
      settle_last <= 1'b0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
      bus.out_clause_coefficients_integer <= '0;
      bus.out_clause_coefficients_boolean <= '0;
      bus.out_clause_index   <= '0;
      bus.out_clause_valid   <= 1'b0;
      bus.out_busy           <= 1'b0;
      bus.out_setup_done     <= 1'b0;
      bus.out_checker_enable <= 1'b0;
`ifdef CLAUSE_FORMULA_LOADER_CHECKSUM_EN
      bus.out_checksum       <= '0;
`endif
    end else begin
      if (wr_ok && bus.in_wr_en)
        mem[bus.in_wr_index] <= {bus.in_wr_coefficients_integer, bus.in_wr_coefficients_boolean};
      case (state)
        IDLE, DONE: begin
          if (bus.in_start) begin
            state                  <= LOAD;
            cnt                    <= '0;
            bus.out_busy           <= 1'b1;
            bus.out_setup_done     <= 1'b0;
            bus.out_checker_enable <= 1'b0;
`ifdef CLAUSE_FORMULA_LOADER_CHECKSUM_EN
            bus.out_checksum       <= '0;
`endif
          end else if (state == DONE && bus.in_wr_en) begin
            // formula changed under the checker: it is stale until reloaded
            state                  <= IDLE;
            bus.out_setup_done     <= 1'b0;
            bus.out_checker_enable <= 1'b0;
          end
        end
        LOAD: begin
          bus.out_clause_coefficients_integer <= cur[EW-1:BW];
          bus.out_clause_coefficients_boolean <= cur[BW-1:0];
          bus.out_clause_index <= cnt;
          bus.out_clause_valid <= 1'b1;
`ifdef CLAUSE_FORMULA_LOADER_CHECKSUM_EN
          bus.out_checksum     <= bus.out_checksum ^ cur;
`endif
          if (cnt == CW'(N-1)) begin
            state       <= SETTLE;
            settle_last <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SETTLE: begin
          // two settle edges: valid drops on the first, done rises on the second
          bus.out_clause_valid <= 1'b0;
          if (settle_last) begin
            state                  <= DONE;
            bus.out_busy           <= 1'b0;
            bus.out_setup_done     <= 1'b1;
            bus.out_checker_enable <= 1'b1;
          end else begin
            settle_last <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_clause_formula_loader.sv
// Directed bench for clause_formula_loader with a timeline-based reference model.
module tb_clause_formula_loader;
  localparam int N  = 4;
  localparam int IW = 12;
  localparam int BW = 4;
  localparam int CW = 2;
  localparam int EW = IW+BW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clause_formula_loader_if #(
    .MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT(4),
    .MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT(2),
    .MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX(1),
    .MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX(1),
    .MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX(2)
  ) bus_if ();

  clause_formula_loader #(
    .MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT(4),
    .MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT(2),
    .MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX(1),
    .MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX(1),
    .MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX(2)
  ) dut (
    .in_clk(clk),
    .in_reset(rst),
    .bus(bus_if)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // model: formula contents, start edge of the current load, snapshot streamed
  logic [EW-1:0] m_mem  [N];
  logic [EW-1:0] m_snap [N];
  bit            m_run;
  int            m_t;
  logic [CW-1:0] h_idx;
  logic [EW-1:0] h_ent;
  logic [EW-1:0] h_cks;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_mem[i] = '0; m_snap[i] = '0; end
    m_run = 0; m_t = 0; h_idx = '0; h_ent = '0; h_cks = '0;
  endtask

  // applied once per clock edge with the inputs the bench is driving
  task automatic model_step();
    bit acc;
    acc = !m_run || (cyc - m_t) >= N+3;
    if (acc) begin
      if (bus_if.in_wr_en) begin
        m_mem[bus_if.in_wr_index] = {bus_if.in_wr_coefficients_integer, bus_if.in_wr_coefficients_boolean};
        m_run = 0;
      end
      if (bus_if.in_start) begin
        m_run = 1;
        m_t   = cyc;
        for (int i = 0; i < N; i++) m_snap[i] = m_mem[i];
      end
    end
  endtask

  task automatic cmp_all();
    int d, k, lim;
    bit e_valid, e_busy, e_done;
    d = m_run ? cyc - m_t : 0;
    if (m_run && d == 0) h_cks = '0;
    if (m_run && d >= 1) begin
      lim   = (d > N) ? N : d;
      k     = lim - 1;
      h_idx = CW'(k);
      h_ent = m_snap[k];
      h_cks = '0;
      for (int j = 0; j < lim; j++) h_cks ^= m_snap[j];
    end
    e_valid = m_run && d >= 1 && d <= N;
    e_busy  = m_run && d <= N+1;
    e_done  = m_run && d >= N+2;
    chk("valid",  32'(bus_if.out_clause_valid), 32'(e_valid));
    chk("busy",   32'(bus_if.out_busy), 32'(e_busy));
    chk("done",   32'(bus_if.out_setup_done), 32'(e_done));
    chk("enable", 32'(bus_if.out_checker_enable), 32'(e_done));
    chk("index",  32'(bus_if.out_clause_index), 32'(h_idx));
    chk("int",    32'(bus_if.out_clause_coefficients_integer), 32'(h_ent[EW-1:BW]));
    chk("bool",   32'(bus_if.out_clause_coefficients_boolean), 32'(h_ent[BW-1:0]));
`ifdef CLAUSE_FORMULA_LOADER_CHECKSUM_EN
    chk("checksum", 32'(bus_if.out_checksum), 32'(h_cks));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rst) model_step();
    @(negedge clk);
    cmp_all();
  endtask

  task automatic wr(input logic [CW-1:0] idx, input logic [IW-1:0] iv, input logic [BW-1:0] bv);
    bus_if.in_wr_en = 1'b1;
    bus_if.in_wr_index = idx;
    bus_if.in_wr_coefficients_integer = iv;
    bus_if.in_wr_coefficients_boolean = bv;
    tick();
    bus_if.in_wr_en = 1'b0;
  endtask

  task automatic start_pulse();
    bus_if.in_start = 1'b1;
    tick();
    bus_if.in_start = 1'b0;
  endtask

  int vc;

  initial begin
    bus_if.in_wr_en = 1'b0;
    bus_if.in_wr_index = '0;
    bus_if.in_wr_coefficients_integer = '0;
    bus_if.in_wr_coefficients_boolean = '0;
    bus_if.in_start = 1'b0;
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_done", 32'(bus_if.out_setup_done), 32'h0);
    chk("rst_valid", 32'(bus_if.out_clause_valid), 32'h0);

    // empty formula: zeros streamed, done six edges after start
    start_pulse();
    repeat (5) tick();
    chk("empty_done_d5", 32'(bus_if.out_setup_done), 32'h0);
    tick();
    chk("empty_done_d6", 32'(bus_if.out_setup_done), 32'h1);
    chk("empty_en_d6", 32'(bus_if.out_checker_enable), 32'h1);

    wr(2'd0, 12'h111, 4'h1);
    wr(2'd1, 12'h222, 4'h2);
    wr(2'd2, 12'h333, 4'h3);
    wr(2'd3, 12'h444, 4'h4);
    start_pulse();
    repeat (2) tick();
    chk("seq_idx1", 32'(bus_if.out_clause_index), 32'h1);
    chk("seq_int1", 32'(bus_if.out_clause_coefficients_integer), 32'h222);
    repeat (6) tick();
    chk("hold_valid", 32'(bus_if.out_clause_valid), 32'h0);
    chk("hold_idx", 32'(bus_if.out_clause_index), 32'h3);
    chk("hold_int", 32'(bus_if.out_clause_coefficients_integer), 32'h444);
    chk("hold_bool", 32'(bus_if.out_clause_coefficients_boolean), 32'h4);
`ifdef CLAUSE_FORMULA_LOADER_CHECKSUM_EN
    chk("cks_4444", 32'(bus_if.out_checksum), 32'h4444);
`endif

    // write during LOAD is dropped
    start_pulse();
    tick();
    wr(2'd2, 12'hABC, 4'hF);
    repeat (6) tick();
    start_pulse();
    repeat (3) tick();
    chk("drop_idx2", 32'(bus_if.out_clause_index), 32'h2);
    chk("drop_int2", 32'(bus_if.out_clause_coefficients_integer), 32'h333);
    repeat (5) tick();

    // write in DONE makes the formula stale
    wr(2'd1, 12'h5A5, 4'h9);
    chk("stale_done", 32'(bus_if.out_setup_done), 32'h0);
    chk("stale_en", 32'(bus_if.out_checker_enable), 32'h0);
    chk("stale_busy", 32'(bus_if.out_busy), 32'h0);
    start_pulse();
    repeat (2) tick();
    chk("new_int1", 32'(bus_if.out_clause_coefficients_integer), 32'h5A5);
    chk("new_bool1", 32'(bus_if.out_clause_coefficients_boolean), 32'h9);
    repeat (6) tick();

    // asynchronous reset at the third valid cycle
    start_pulse();
    repeat (3) tick();
    rst = 1'b1;
    #1;
    model_reset();
    cmp_all();
    chk("arst_valid", 32'(bus_if.out_clause_valid), 32'h0);
    chk("arst_int", 32'(bus_if.out_clause_coefficients_integer), 32'h0);
    chk("arst_busy", 32'(bus_if.out_busy), 32'h0);
    tick();
    rst = 1'b0;
    start_pulse();
    repeat (5) tick();
    chk("post_rst_done_d5", 32'(bus_if.out_setup_done), 32'h0);
    tick();
    chk("post_rst_done_d6", 32'(bus_if.out_setup_done), 32'h1);
    chk("post_rst_int", 32'(bus_if.out_clause_coefficients_integer), 32'h0);

    // start during LOAD is ignored
    start_pulse();
    vc = 0;
    for (int i = 1; i <= 10; i++) begin
      bus_if.in_start = (i == 2);
      tick();
      if (bus_if.out_clause_valid) vc++;
      if (i == 5) chk("restart_done_d5", 32'(bus_if.out_setup_done), 32'h0);
      if (i == 6) chk("restart_done_d6", 32'(bus_if.out_setup_done), 32'h1);
    end
    bus_if.in_start = 1'b0;
    chk("restart_valid_cnt", 32'(vc), 32'd4);

    // write and start together in DONE: new data is streamed
    bus_if.in_start = 1'b1;
    wr(2'd0, 12'hABC, 4'hF);
    bus_if.in_start = 1'b0;
    tick();
    chk("wrstart_idx0", 32'(bus_if.out_clause_index), 32'h0);
    chk("wrstart_int0", 32'(bus_if.out_clause_coefficients_integer), 32'hABC);
    chk("wrstart_bool0", 32'(bus_if.out_clause_coefficients_boolean), 32'hF);
    repeat (7) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
